puzzle_board: RTL
=================

PUZZLE_BOARD -- requirements
Module: puzzle_board

Interface
REQ-001 SHALL have these ports: clk, input, 1, pixel-domain clock.
REQ-002 SHALL have these ports: rst, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have these ports: btn_up, btn_down, btn_left, btn_right, input, 1 each, debounced direction levels.
REQ-004 SHALL have these ports: shuffle_req, input, 1, debounced shuffle level.
REQ-005 SHALL have these ports: tiles, output, 64, board layout; cell i (i = row*4 + col, row 0 top) holds the tile number in bits [4i+3:4i]; 0 = blank.
REQ-006 SHALL have these ports: blank_idx, output, 4, cell index of the blank.
REQ-007 SHALL have these ports: busy, output, 1, high while the FSM is not IDLE.
REQ-008 SHALL have these ports: solved, output, 1, board equals the solved layout.
REQ-009 SHALL have these ports: illegal, output, 1, one-cycle pulse on a rejected move.
REQ-010 SHALL have these ports: move_count, output, 10, accepted moves, saturating.

Function
REQ-011 SHALL register each button input and form a one-cycle rising-edge strobe: level high now AND registered level low.
REQ-012 SHALL define the move directions as follows: up = blank moves down (+4), down = blank moves up (-4), left = blank moves right (+1), right = blank moves left (-1).
REQ-013 SHALL define a move as legal only if it stays on the board: up needs row<3, down needs row>0, left needs col<3, right needs col>0.
REQ-014 SHALL use an FSM with states IDLE, SWAP, CHECK and SHUFFLE.
REQ-015 SHALL process direction strobes as follows: in IDLE, exactly one direction strobe plus a legal move -> latch the target cell and go to SWAP.
REQ-016 SHALL handle a rejected move as follows: in IDLE, exactly one direction strobe plus an illegal move -> illegal=1 for one cycle, stay in IDLE, no other change.
REQ-017 SHALL ignore the cycle entirely when two or more direction strobes occur in the same cycle.
REQ-018 SHALL perform SWAP in one cycle: the target tile moves into the old blank cell, the target cell becomes 0, blank_idx is updated, move_count increments (saturating at 1023), then go to CHECK.
REQ-019 SHALL perform CHECK in one cycle: register solved from the new tiles, then go to IDLE.
REQ-020 SHALL update tiles on the 2nd clock edge after the strobe cycle and solved on the 3rd.
REQ-021 SHALL drop every strobe that occurs while busy=1; strobes SHALL NOT be queued.
REQ-022 SHALL define the solved layout as cell i = i+1 for i=0..14 and cell 15 = 0.
REQ-023 SHALL keep exactly one blank on the board at all times.

Reset
REQ-024 SHALL, with rst=0 at a clk edge, load the layout 3,15,4,11,1,10,7,14,9,5,8,0,2,12,13,6 into cells 0..15.
REQ-025 SHALL set the following reset values: blank_idx=11, state=IDLE, busy=0, illegal=0, move_count=0, solved=0, button registers=0.
REQ-026 SHALL let reset take precedence over any in-progress SWAP, CHECK or SHUFFLE.

Configuration
REQ-027 SHALL, with SHUFFLE_EN defined, handle a shuffle_req strobe in IDLE by entering SHUFFLE.
REQ-028 SHALL, in SHUFFLE, apply one candidate move per cycle, taking the direction from lfsr[1:0] (00 up, 01 down, 10 left, 11 right).
REQ-029 SHALL, in SHUFFLE, skip illegal candidates without a pulse, and SHALL count only legal moves.
REQ-030 SHALL leave SHUFFLE after 64 legal moves: go to CHECK and clear move_count to 0.
REQ-031 SHALL, with SHUFFLE_EN defined, run a free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) that advances every cycle.
REQ-032 SHALL, without SHUFFLE_EN, keep the shuffle_req port, ignore it, and contain no LFSR logic.

Structure
REQ-033 SHALL put the following in shared package puzzle_pkg: the state enum, the direction enum, the RESET_LAYOUT and SOLVED_LAYOUT constants, and N_SHUFFLE=64.
REQ-034 SHALL implement the LFSR as sub-module lfsr16, instantiated only under SHUFFLE_EN.
REQ-035 SHALL reuse this block unchanged for upstream control of the existing 16-position tile renderer.

Verification
REQ-036 SHALL cover: reset, btn_up edge -> after 2 edges cell11=6, cell15=0, blank_idx=15, move_count=1; solved=0 after the next edge.
REQ-037 SHALL cover: reset, btn_left edge (blank col 3) -> illegal pulse of one cycle; tiles, blank_idx and move_count unchanged.
REQ-038 SHALL cover: btn_up and btn_right rising in the same cycle -> no change, no illegal pulse.
REQ-039 SHALL cover: btn_right edge then btn_down edge one cycle later (busy) -> only the right move applies: cell11=8, cell10=0, move_count=1.
REQ-040 SHALL cover: btn_up edge, rst=0 during SWAP -> next edge gives the reset layout and move_count=0.
REQ-041 SHALL cover, with SHUFFLE_EN: shuffle_req edge -> busy for at least 66 cycles; afterwards move_count=0, exactly one zero in tiles, and tiles is a permutation of 0..15.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types and constants for the 15-puzzle board controller.
// Build option: SHUFFLE_EN enables the LFSR-driven shuffle mode.
package puzzle_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWAP,
        S_CHECK,
        S_SHUFFLE
    } state_t;

    // Encoding matches lfsr[1:0] so shuffle can cast it directly
    typedef enum logic [1:0] {
        D_UP    = 2'b00,
        D_DOWN  = 2'b01,
        D_LEFT  = 2'b10,
        D_RIGHT = 2'b11
    } dir_t;

    localparam logic [63:0] RESET_LAYOUT  = 64'h6DC2_0859_E7A1_B4F3;
    localparam logic [63:0] SOLVED_LAYOUT = 64'h0FED_CBA9_8765_4321;
    localparam logic [3:0]  RESET_BLANK   = 4'd11;
    localparam int          N_SHUFFLE     = 64;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    function automatic logic move_ok(logic [3:0] b, dir_t d);
        logic ok;
        unique case (d)
            D_UP:    ok = (b[3:2] != 2'd3);
            D_DOWN:  ok = (b[3:2] != 2'd0);
            D_LEFT:  ok = (b[1:0] != 2'd3);
            D_RIGHT: ok = (b[1:0] != 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] move_tgt(logic [3:0] b, dir_t d);
        logic [3:0] t;
        unique case (d)
            D_UP:    t = b + 4'd4;
            D_DOWN:  t = b - 4'd4;
            D_LEFT:  t = b + 4'd1;
            D_RIGHT: t = b - 4'd1;
            default: t = b;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/puzzle_board_if.sv
// Button inputs and board-state outputs of the puzzle controller.
// Master drives the debounced levels; slave is the controller.
interface puzzle_board_if;

    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        shuffle_req;
    logic [63:0] tiles;
    logic [3:0]  blank_idx;
    logic        busy;
    logic        solved;
    logic        illegal;
    logic [9:0]  move_count;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, shuffle_req,
        input  tiles, blank_idx, busy, solved, illegal, move_count
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, shuffle_req,
        output tiles, blank_idx, busy, solved, illegal, move_count
    );

endinterface

// File: rtl/puzzle_board_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
// Synchronous active-low reset loads the seed; used by SHUFFLE_EN only.
module lfsr16
    import puzzle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] rnd
);

    logic [15:0] q;
    logic        fb;

    assign fb  = q[15] ^ q[13] ^ q[12] ^ q[10];
    assign rnd = q[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/puzzle_board.sv
// 4x4 sliding-puzzle board controller; rst is synchronous active-low.
// Define SHUFFLE_EN to add the LFSR-driven shuffle mode.
module puzzle_board
    import puzzle_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    puzzle_board_if.slave bus
);

    state_t      state_q, state_n;
    logic [3:0]  btn_q;
    logic [3:0]  btn_now;
    logic [3:0]  strb;
    logic [3:0]  sel;
    logic        one_hot;
    dir_t        dir;
    logic [63:0] tiles_q, tiles_n;
    logic [3:0]  blank_q, blank_n;
    logic [3:0]  tgt_q, tgt_n;
    logic [9:0]  cnt_q, cnt_n;
    logic        solved_q, solved_n;
    logic        ill_q, ill_n;

`ifdef SHUFFLE_EN
    logic        shf_q;
    logic        shf_strb;
    logic [1:0]  rnd;
    dir_t        sdir;
    logic [3:0]  stgt;
    logic [6:0]  shuf_q, shuf_n;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (rnd)
    );

    assign shf_strb = bus.shuffle_req & ~shf_q;
    assign sdir     = dir_t'(rnd);
    assign stgt     = move_tgt(blank_q, sdir);
`endif

    // Bit order equals dir_t encoding: up, down, left, right
    assign btn_now = {bus.btn_right, bus.btn_left,
                      bus.btn_down, bus.btn_up};
    assign strb    = btn_now & ~btn_q;
    assign one_hot = (strb != 4'd0) &&
                     ((strb & (strb - 4'd1)) == 4'd0);
    assign sel     = one_hot ? strb : 4'd0;

    always_comb begin
        dir = D_UP;
        unique case (1'b1)
            sel[0]:  dir = D_UP;
            sel[1]:  dir = D_DOWN;
            sel[2]:  dir = D_LEFT;
            sel[3]:  dir = D_RIGHT;
            default: dir = D_UP;
        endcase
    end

    always_comb begin
        state_n  = state_q;
        tiles_n  = tiles_q;
        blank_n  = blank_q;
        tgt_n    = tgt_q;
        cnt_n    = cnt_q;
        solved_n = solved_q;
        ill_n    = 1'b0;
`ifdef SHUFFLE_EN
        shuf_n   = shuf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (one_hot) begin
                    if (move_ok(blank_q, dir)) begin
                        tgt_n   = move_tgt(blank_q, dir);
                        state_n = S_SWAP;
                    end else begin
                        ill_n = 1'b1;
                    end
                end
`ifdef SHUFFLE_EN
                else if (shf_strb && strb == 4'd0) begin
                    shuf_n  = 7'd0;
                    state_n = S_SHUFFLE;
                end
`endif
            end
            S_SWAP: begin
                tiles_n[{blank_q, 2'b00} +: 4] =
                    tiles_q[{tgt_q, 2'b00} +: 4];
                tiles_n[{tgt_q, 2'b00} +: 4] = 4'd0;
                blank_n = tgt_q;
                if (cnt_q != 10'd1023) begin
                    cnt_n = cnt_q + 10'd1;
                end
                state_n = S_CHECK;
            end
            S_CHECK: begin
                solved_n = (tiles_q == SOLVED_LAYOUT);
                state_n  = S_IDLE;
            end
            S_SHUFFLE: begin
`ifdef SHUFFLE_EN
                // Illegal candidates are skipped silently
                if (move_ok(blank_q, sdir)) begin
                    tiles_n[{blank_q, 2'b00} +: 4] =
                        tiles_q[{stgt, 2'b00} +: 4];
                    tiles_n[{stgt, 2'b00} +: 4] = 4'd0;
                    blank_n = stgt;
                    shuf_n  = shuf_q + 7'd1;
                    if (shuf_q == 7'(N_SHUFFLE - 1)) begin
                        cnt_n   = 10'd0;
                        state_n = S_CHECK;
                    end
                end
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            btn_q    <= 4'd0;
            tiles_q  <= RESET_LAYOUT;
            blank_q  <= RESET_BLANK;
            tgt_q    <= 4'd0;
            cnt_q    <= 10'd0;
            solved_q <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            btn_q    <= btn_now;
            tiles_q  <= tiles_n;
            blank_q  <= blank_n;
            tgt_q    <= tgt_n;
            cnt_q    <= cnt_n;
            solved_q <= solved_n;
            ill_q    <= ill_n;
        end
    end

`ifdef SHUFFLE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            shf_q  <= 1'b0;
            shuf_q <= 7'd0;
        end else begin
            shf_q  <= bus.shuffle_req;
            shuf_q <= shuf_n;
        end
    end
`endif

    assign bus.tiles      = tiles_q;
    assign bus.blank_idx  = blank_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.solved     = solved_q;
    assign bus.illegal    = ill_q;
    assign bus.move_count = cnt_q;

endmodule
